// File: rtl/pbus_multi_slave_bridge.sv
// pbus slave bridge fanning one 32-bit port out to NUM_CH IP register channels.
// 32-bit accesses to a 16-bit IP are issued as two beats, low half first.
module pbus_multi_slave_bridge #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int IP_DW   = 16,
  parameter int CH_LSB  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                    pbus_clk,
  input  logic                    pbus_rst,
  input  logic [31:0]             pbus_addr_i,
  input  logic                    pbus_write_i,
  input  logic                    pbus_sel_i,
  input  logic                    pbus_enable_i,
  input  logic [31:0]             pbus_wdata_i,
  output logic [31:0]             pbus_rdata_o,
  output logic                    pbus_ready_o,
  output logic                    pbus_slverr_o,
  output logic [ADDR_W-1:0]       bus2ip_addr_o,
  output logic [IP_DW-1:0]        bus2ip_data_o,
  output logic [NUM_CH-1:0]       bus2ip_rd_ce_o,
  output logic [NUM_CH-1:0]       bus2ip_wr_ce_o,
  input  logic [NUM_CH*IP_DW-1:0] ip2bus_data_i,
  input  logic [NUM_CH-1:0]       ip2bus_ack_i
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CE, WAIT, RESP} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] word_q, word_n;
  logic [31:0]       wdata_q, wdata_n;
  logic              write_q, write_n;
  logic [CHW-1:0]    ch_q, ch_n;
  logic              beat_q, beat_n;
  logic              abort_q, abort_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [31:0]       cap_q, cap_n;

  logic [31:0]       rdata_q, rdata_n;
  logic              ready_q, ready_n;
  logic              slverr_q, slverr_n;
  logic [ADDR_W-1:0] ip_addr_q, ip_addr_n;
  logic [IP_DW-1:0]  ip_data_q, ip_data_n;
  logic [NUM_CH-1:0] rd_ce_q, rd_ce_n;
  logic [NUM_CH-1:0] wr_ce_q, wr_ce_n;

  logic              issue;
  logic              ack;
  logic              last;
  logic              tmo;
  logic              dec_err;
  logic [IP_DW-1:0]  beat_rd;

  // Address bits above the channel field must be zero so aliases are rejected.
  assign dec_err = (pbus_addr_i[1:0] != 2'b00) ||
                   ((pbus_addr_i >> CH_LSB) >= 32'(NUM_CH));

  assign ack     = ip2bus_ack_i[ch_q];
  assign beat_rd = ip2bus_data_i[ch_q*IP_DW +: IP_DW];
  assign last    = (IP_DW == 32) || beat_q;
  assign tmo     = (TIMEOUT != 0) && (cnt_q == TMAX - 1'b1);

  always_comb begin
    state_n   = state;
    word_n    = word_q;
    wdata_n   = wdata_q;
    write_n   = write_q;
    ch_n      = ch_q;
    beat_n    = beat_q;
    abort_n   = abort_q;
    cnt_n     = cnt_q;
    cap_n     = cap_q;
    rdata_n   = '0;
    ready_n   = 1'b0;
    slverr_n  = 1'b0;
    ip_addr_n = ip_addr_q;
    ip_data_n = ip_data_q;
    rd_ce_n   = '0;
    wr_ce_n   = '0;
    issue     = 1'b0;

    unique case (state)
      IDLE: begin
        if (pbus_sel_i && !pbus_enable_i) begin
          word_n  = pbus_addr_i[ADDR_W+1:2];
          wdata_n = pbus_wdata_i;
          write_n = pbus_write_i;
          ch_n    = pbus_addr_i[CH_LSB +: CHW];
          beat_n  = 1'b0;
          abort_n = 1'b0;
          cnt_n   = '0;
          cap_n   = '0;
          if (dec_err) begin
            state_n  = RESP;
            ready_n  = 1'b1;
            slverr_n = 1'b1;
          end else begin
            state_n = CE;
            issue   = 1'b1;
          end
        end
      end
      CE, WAIT: begin
        abort_n = abort_q | !pbus_sel_i;
        if (ack) begin
          if (!write_q)
            cap_n = cap_q | (32'(beat_rd) << {beat_q, 4'b0});
          if (abort_n) begin
            state_n = IDLE;
          end else if (last) begin
            state_n = RESP;
            ready_n = 1'b1;
            rdata_n = write_q ? 32'h0 : cap_n;
          end else begin
            state_n = CE;
            beat_n  = 1'b1;
            cnt_n   = '0;
            issue   = 1'b1;
          end
        end else if (state == WAIT && tmo) begin
          state_n  = abort_n ? IDLE : RESP;
          ready_n  = !abort_n;
          slverr_n = !abort_n;
        end else begin
          state_n = WAIT;
          if (state == WAIT && cnt_q != '1)
            cnt_n = cnt_q + 1'b1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (issue) begin
      ip_addr_n = (IP_DW == 32) ? word_n
                                : {word_n[ADDR_W-2:0], beat_n};
      ip_data_n = IP_DW'(wdata_n >> {beat_n, 4'b0});
      if (write_n) wr_ce_n = NUM_CH'(1) << ch_n;
      else         rd_ce_n = NUM_CH'(1) << ch_n;
    end
  end

  always_ff @(posedge pbus_clk or posedge pbus_rst) begin
    if (pbus_rst) begin
      state     <= IDLE;
      word_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      ch_q      <= '0;
      beat_q    <= 1'b0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      slverr_q  <= 1'b0;
      ip_addr_q <= '0;
      ip_data_q <= '0;
      rd_ce_q   <= '0;
      wr_ce_q   <= '0;
    end else begin
      state     <= state_n;
      word_q    <= word_n;
      wdata_q   <= wdata_n;
      write_q   <= write_n;
      ch_q      <= ch_n;
      beat_q    <= beat_n;
      abort_q   <= abort_n;
      cnt_q     <= cnt_n;
      cap_q     <= cap_n;
      rdata_q   <= rdata_n;
      ready_q   <= ready_n;
      slverr_q  <= slverr_n;
      ip_addr_q <= ip_addr_n;
      ip_data_q <= ip_data_n;
      rd_ce_q   <= rd_ce_n;
      wr_ce_q   <= wr_ce_n;
    end
  end

  assign pbus_rdata_o   = rdata_q;
  assign pbus_ready_o   = ready_q;
  assign pbus_slverr_o  = slverr_q;
  assign bus2ip_addr_o  = ip_addr_q;
  assign bus2ip_data_o  = ip_data_q;
  assign bus2ip_rd_ce_o = rd_ce_q;
  assign bus2ip_wr_ce_o = wr_ce_q;

endmodule

// File: tb/tb_pbus_multi_slave_bridge.sv
// Directed bench: a 32-bit-IP bridge and a 16-bit-IP bridge on shared pbus wires.
// Outputs are sampled on the falling edge; IP acks are driven reactively there.
module tb_pbus_multi_slave_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        write = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] wdata = '0;
  logic        sel32 = 1'b0;
  logic        sel16 = 1'b0;

  logic [31:0] rdata32, rdata16;
  logic        ready32, ready16;
  logic        err32, err16;
  logic [13:0] addr32, addr16;
  logic [31:0] dat32;
  logic [15:0] dat16;
  logic [1:0]  rd32, wr32, rd16, wr16;
  logic [63:0] ipd32 = '0;
  logic [31:0] ipd16 = '0;
  logic [1:0]  ack32 = '0;
  logic [1:0]  ack16 = '0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pbus_multi_slave_bridge #(
    .NUM_CH(2), .ADDR_W(14), .IP_DW(32), .CH_LSB(16), .TIMEOUT(4)
  ) u_dut32 (
    .pbus_clk(clk), .pbus_rst(rst),
    .pbus_addr_i(addr), .pbus_write_i(write),
    .pbus_sel_i(sel32), .pbus_enable_i(enable),
    .pbus_wdata_i(wdata), .pbus_rdata_o(rdata32),
    .pbus_ready_o(ready32), .pbus_slverr_o(err32),
    .bus2ip_addr_o(addr32), .bus2ip_data_o(dat32),
    .bus2ip_rd_ce_o(rd32), .bus2ip_wr_ce_o(wr32),
    .ip2bus_data_i(ipd32), .ip2bus_ack_i(ack32)
  );

  pbus_multi_slave_bridge #(
    .NUM_CH(2), .ADDR_W(14), .IP_DW(16), .CH_LSB(16), .TIMEOUT(8)
  ) u_dut16 (
    .pbus_clk(clk), .pbus_rst(rst),
    .pbus_addr_i(addr), .pbus_write_i(write),
    .pbus_sel_i(sel16), .pbus_enable_i(enable),
    .pbus_wdata_i(wdata), .pbus_rdata_o(rdata16),
    .pbus_ready_o(ready16), .pbus_slverr_o(err16),
    .bus2ip_addr_o(addr16), .bus2ip_data_o(dat16),
    .bus2ip_rd_ce_o(rd16), .bus2ip_wr_ce_o(wr16),
    .ip2bus_data_i(ipd16), .ip2bus_ack_i(ack16)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Setup phase in the next cycle; returns at the T1 falling edge.
  task automatic setup(input bit to16, input logic [31:0] a,
                       input bit wr, input logic [31:0] d);
    @(negedge clk);
    addr   = a;
    write  = wr;
    wdata  = d;
    sel32  = !to16;
    sel16  = to16;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic idle();
    sel32  = 1'b0;
    sel16  = 1'b0;
    enable = 1'b0;
  endtask

  logic [31:0] bad_addr [2];

  initial begin
    bad_addr[0] = 32'h0002_0000;
    bad_addr[1] = 32'h0000_0002;

    repeat (2) @(negedge clk);
    check("rst_ready32", ready32, 0);
    check("rst_rdata32", rdata32, 0);
    check("rst_addr32", addr32, 0);
    check("rst_ce16", {rd16, wr16}, 0);
    check("rst_err16", err16, 0);
    rst = 1'b0;

    // 32-bit IP write, ack in the CE cycle
    setup(0, 32'h0001_0010, 1, 32'hDEAD_BEEF);
    check("w32_wrce", wr32, 2'b10);
    check("w32_rdce", rd32, 0);
    check("w32_addr", addr32, 14'h0004);
    check("w32_data", dat32, 32'hDEAD_BEEF);
    check("w32_rdy_t1", ready32, 0);
    ack32 = 2'b10;
    @(negedge clk);
    ack32 = '0;
    check("w32_ready", ready32, 1);
    check("w32_err", err32, 0);
    check("w32_ce_off", wr32, 0);
    idle();

    // 16-bit IP read, two zero-wait beats
    setup(1, 32'h0000_0008, 0, 0);
    check("r16_b0_ce", rd16, 2'b01);
    check("r16_b0_addr", addr16, 14'h0004);
    ack16 = 2'b01;
    ipd16[15:0] = 16'h1234;
    @(negedge clk);
    check("r16_b1_ce", rd16, 2'b01);
    check("r16_b1_addr", addr16, 14'h0005);
    ipd16[15:0] = 16'h5678;
    @(negedge clk);
    ack16 = '0;
    check("r16_ready", ready16, 1);
    check("r16_rdata", rdata16, 32'h5678_1234);
    check("r16_err", err16, 0);
    idle();

    // 16-bit IP write, beat-0 ack delayed three cycles
    setup(1, 32'h0000_0010, 1, 32'hAAAA_5555);
    check("w16_b0_ce", wr16, 2'b01);
    check("w16_b0_addr", addr16, 14'h0008);
    check("w16_b0_data", dat16, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w16_wait_ce", wr16, 0);
      check("w16_wait_data", dat16, 16'h5555);
      check("w16_wait_rdy", ready16, 0);
      if (i == 2) ack16 = 2'b01;
    end
    @(negedge clk);
    check("w16_b1_ce", wr16, 2'b01);
    check("w16_b1_addr", addr16, 14'h0009);
    check("w16_b1_data", dat16, 16'hAAAA);
    @(negedge clk);
    ack16 = '0;
    check("w16_ready", ready16, 1);
    check("w16_err", err16, 0);
    check("w16_rdata", rdata16, 0);
    idle();

    // timeout with no ack, then a back-to-back clean read
    setup(0, 32'h0000_0020, 0, 0);
    check("to_ce", rd32, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_wait_ce", rd32, 0);
      check("to_wait_rdy", ready32, 0);
    end
    @(negedge clk);
    check("to_ready", ready32, 1);
    check("to_err", err32, 1);
    check("to_rdata", rdata32, 0);
    idle();
    ipd32[63:32] = 32'hCAFE_F00D;
    setup(0, 32'h0001_0004, 0, 0);
    check("b2b_ce", rd32, 2'b10);
    check("b2b_addr", addr32, 14'h0001);
    ack32 = 2'b10;
    @(negedge clk);
    ack32 = '0;
    check("b2b_ready", ready32, 1);
    check("b2b_err", err32, 0);
    check("b2b_rdata", rdata32, 32'hCAFE_F00D);
    idle();

    // decode errors
    for (int i = 0; i < 2; i++) begin
      setup(0, bad_addr[i], 0, 0);
      check("dec_ready", ready32, 1);
      check("dec_err", err32, 1);
      check("dec_ce", {rd32, wr32}, 0);
      idle();
    end

    // asynchronous reset during WAIT
    setup(0, 32'h0000_0040, 0, 0);
    check("rw_addr", addr32, 14'h0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw_addr0", addr32, 0);
    check("rw_ce0", rd32, 0);
    check("rw_rdy0", ready32, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    setup(0, 32'h0001_0008, 1, 32'h0000_0001);
    check("rw_next_ce", wr32, 2'b10);
    check("rw_next_addr", addr32, 14'h0002);
    ack32 = 2'b10;
    @(negedge clk);
    ack32 = '0;
    check("rw_next_rdy", ready32, 1);
    check("rw_next_err", err32, 0);
    idle();

    // sel dropped during beat 0 of a 16-bit read
    setup(1, 32'h0000_0010, 0, 0);
    check("ab_ce", rd16, 2'b01);
    idle();
    ack16 = 2'b01;
    @(negedge clk);
    ack16 = '0;
    check("ab_no_b1", rd16, 0);
    check("ab_rdy_a", ready16, 0);
    @(negedge clk);
    check("ab_rdy_b", ready16, 0);
    check("ab_ce_b", rd16, 0);
    setup(1, 32'h0000_0004, 0, 0);
    check("ab_next_addr", addr16, 14'h0002);
    ack16 = 2'b01;
    ipd16[15:0] = 16'hBEEF;
    @(negedge clk);
    check("ab_next_b1", addr16, 14'h0003);
    ipd16[15:0] = 16'h0BAD;
    @(negedge clk);
    ack16 = '0;
    check("ab_next_rdy", ready16, 1);
    check("ab_next_rdata", rdata16, 32'h0BAD_BEEF);
    idle();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
